// File: rtl/clock_enable_gen.sv
// Clock-enable generator: stretched system reset plus CPU and pixel
// clock-enable pulses derived from a single PLL clock.
module clock_enable_gen #(
    parameter int unsigned CPU_DIV_NORM  = 16,
    parameter int unsigned CPU_DIV_TURBO = 8,
    parameter int unsigned PIX_DIV       = 4,
    parameter int unsigned RST_CYCLES    = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic turbo,
    input  logic hold,
    output logic cpu_ce,
    output logic pix_ce,
    output logic sys_rst,
    output logic turbo_act
);

    // Terminal counts; a divisor of 256 lands on 8'hFF.
    localparam logic [7:0]  TC_NORM  = 8'(CPU_DIV_NORM - 1);
    localparam logic [7:0]  TC_TURBO = 8'(CPU_DIV_TURBO - 1);
    localparam logic [7:0]  TC_PIX   = 8'(PIX_DIV - 1);
    localparam logic [15:0] TC_RST   = 16'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET,
        STRETCH,
        RUN
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] rst_cnt;
    logic [15:0] rst_cnt_nx;
    logic [7:0]  cpu_cnt;
    logic [7:0]  cpu_cnt_nx;
    logic [7:0]  pix_cnt;
    logic [7:0]  pix_cnt_nx;
    logic        turbo_nx;
    logic        cpu_ce_nx;
    logic        pix_ce_nx;
    logic        sys_rst_nx;
    logic        cpu_wrap;
    logic        pix_wrap;

    assign cpu_wrap = (cpu_cnt == (turbo_act ? TC_TURBO : TC_NORM));
    assign pix_wrap = (pix_cnt == TC_PIX);

    always_comb begin
        state_nx   = state;
        rst_cnt_nx = rst_cnt;
        cpu_cnt_nx = 8'd0;
        pix_cnt_nx = 8'd0;
        turbo_nx   = turbo_act;
        cpu_ce_nx  = 1'b0;
        pix_ce_nx  = 1'b0;
        unique case (state)
            RESET: begin
                state_nx   = STRETCH;
                rst_cnt_nx = 16'd0;
                turbo_nx   = turbo;
            end
            STRETCH: begin
                if (rst_cnt == TC_RST) begin
                    state_nx   = RUN;
                    rst_cnt_nx = 16'd0;
                end else begin
                    rst_cnt_nx = rst_cnt + 16'd1;
                end
            end
            RUN: begin
                // A held wrap still restarts the period so phase is kept.
                if (cpu_wrap) begin
                    cpu_cnt_nx = 8'd0;
                    turbo_nx   = turbo;
                    cpu_ce_nx  = ~hold;
                end else begin
                    cpu_cnt_nx = cpu_cnt + 8'd1;
                end
                if (pix_wrap) begin
                    pix_cnt_nx = 8'd0;
                    pix_ce_nx  = 1'b1;
                end else begin
                    pix_cnt_nx = pix_cnt + 8'd1;
                end
            end
            default: begin
                state_nx = RESET;
            end
        endcase
        sys_rst_nx = (state_nx != RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RESET;
            rst_cnt   <= 16'd0;
            cpu_cnt   <= 8'd0;
            pix_cnt   <= 8'd0;
            turbo_act <= 1'b0;
            cpu_ce    <= 1'b0;
            pix_ce    <= 1'b0;
            sys_rst   <= 1'b1;
        end else begin
            state     <= state_nx;
            rst_cnt   <= rst_cnt_nx;
            cpu_cnt   <= cpu_cnt_nx;
            pix_cnt   <= pix_cnt_nx;
            turbo_act <= turbo_nx;
            cpu_ce    <= cpu_ce_nx;
            pix_ce    <= pix_ce_nx;
            sys_rst   <= sys_rst_nx;
        end
    end

endmodule

// File: doc/clock_enable_gen.md
CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 The block SHALL have parameter CPU_DIV_NORM, default 16, giving the clk cycles per cpu_ce pulse in normal mode (legal 2..256).
REQ-002 The block SHALL have parameter CPU_DIV_TURBO, default 8, giving the clk cycles per cpu_ce pulse in turbo mode (legal 2..256).
REQ-003 The block SHALL have parameter PIX_DIV, default 4, giving the clk cycles per pix_ce pulse (legal 2..256).
REQ-004 The block SHALL have parameter RST_CYCLES, default 1024, giving the sys_rst stretch length in clk cycles after rst release (legal 1..65535).
REQ-005 The block SHALL have port clk, input, 1 bit: the PLL output clock; the sole clock.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port turbo, input, 1 bit: 1 selects CPU_DIV_TURBO, 0 selects CPU_DIV_NORM.
REQ-008 The block SHALL have port hold, input, 1 bit: 1 suppresses cpu_ce pulses (DMA/wait).
REQ-009 The block SHALL have port cpu_ce, output, 1 bit: one-clk-wide CPU clock-enable pulse.
REQ-010 The block SHALL have port pix_ce, output, 1 bit: one-clk-wide pixel clock-enable pulse.
REQ-011 The block SHALL have port sys_rst, output, 1 bit: stretched, synchronous, active-high system reset.
REQ-012 The block SHALL have port turbo_act, output, 1 bit: the divide mode currently in effect.

Function
REQ-013 The state machine SHALL have states RESET, STRETCH and RUN.
REQ-014 rst=1 SHALL force RESET on the next edge, from any state.
REQ-015 RESET SHALL go to STRETCH on the first edge with rst=0.
REQ-016 STRETCH SHALL count clk cycles with a 16-bit counter and go to RUN on the edge where the counter reaches RST_CYCLES-1.
REQ-017 sys_rst SHALL be 1 in RESET and STRETCH and 0 only in RUN, so exactly RST_CYCLES+1 cycles of sys_rst=1 follow the last rst=1 cycle.
REQ-018 The CPU divide counter and the pixel divide counter SHALL be held at 0 outside RUN; cpu_ce and pix_ce SHALL be 0 outside RUN.
REQ-019 In RUN, the cpu counter SHALL count 0..D-1 and wrap, where D is the divisor in effect; the cycle with counter = D-1 is the "cpu wrap".
REQ-020 cpu_ce SHALL be registered and asserted for the single cycle after each cpu wrap that occurred with hold=0; the first cpu_ce therefore occurs D cycles after entering RUN.
REQ-021 With hold=1 during a cpu wrap, the pulse SHALL be dropped (not deferred) and the counter SHALL wrap normally, keeping the pulse phase intact.
REQ-022 turbo SHALL be sampled into turbo_act only at a cpu wrap (and on the RESET->STRETCH transition), so a period is never shortened or lengthened mid-count.
REQ-023 The new divisor SHALL take effect starting with the period that begins after that wrap.
REQ-024 The pixel counter SHALL count 0..PIX_DIV-1 independently of turbo and hold; pix_ce SHALL be registered, pulsing in the cycle after each pixel wrap.
REQ-025 Divisor compare SHALL use 8-bit counters; D=256 SHALL be encoded as terminal count 255.
REQ-026 cpu_ce and pix_ce pulses SHALL never exceed one clk cycle in width.

Reset
REQ-027 During rst=1, outputs SHALL register: sys_rst=1, cpu_ce=0, pix_ce=0, turbo_act=0, and all counters 0.
REQ-028 rst asserted mid-STRETCH or mid-RUN SHALL restart the full RST_CYCLES stretch; partial divide periods SHALL be discarded.
REQ-029 No output SHALL be combinationally derived from rst.

Verification
REQ-030 Stretch test (RST_CYCLES=8): rst high 3 cycles, then low -> sys_rst stays 1 for exactly 9 cycles after the last rst-high cycle, then stays 0.
REQ-031 Normal divide (CPU_DIV_NORM=16, turbo=0, hold=0): in RUN, cpu_ce pulses every 16 cycles, first pulse 16 cycles after sys_rst falls; 10 consecutive pulses each exactly 1 cycle wide.
REQ-032 Turbo switch: turbo 0->1 at counter=5 -> the current 16-cycle period completes, turbo_act rises at the wrap, and subsequent pulses are 8 cycles apart with no runt period.
REQ-033 Hold: hold=1 spanning exactly one cpu wrap -> that pulse is absent and the next pulse arrives at its original phase (32 cycles after the previous pulse at D=16).
REQ-034 Pixel enable (PIX_DIV=4): pix_ce pulses every 4 cycles in RUN, unaffected by toggling turbo and hold.
REQ-035 Reset mid-operation: rst pulsed for 1 cycle during RUN -> cpu_ce and pix_ce are 0 next cycle, sys_rst re-stretches the full RST_CYCLES+1 cycles, and turbo_act clears to 0.
